// File: rtl/spi_encoder_reader.sv
// ---------------------------------------------------------------------------
// spi_encoder_reader
// Read-only SPI master for absolute rotary encoders. Clocks in one frame
// MSB-first, extracts the position field and publishes it with a one-cycle
// valid pulse. Works as a one-shot reader or as a continuous poller.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   enable       block enable; start/continuous ignored while low
//   start        one-shot request, only honoured in IDLE
//   continuous   repeat frames back-to-back while enable is high
//   miso         encoder serial data (asynchronous, synchronised here)
//   sclk, cs_n   registered SPI clock and active-low chip select
//   frame_full   last complete raw frame
//   position     position field of frame_full
//   data_valid   one-cycle pulse when frame_full/position update
//   busy         high whenever the reader is not idle
//   frame_count  completed frames, wraps
// ---------------------------------------------------------------------------
module spi_encoder_reader #(
   parameter int   FRAME_BITS = 24,
   parameter int   DATA_MSB   = 21,
   parameter int   DATA_LSB   = 3,
   parameter int   CLK_DIV    = 100,
   parameter int   CS_SETUP   = 100,
   parameter int   CS_HOLD    = 100,
   parameter int   CS_IDLE    = 200,
   parameter logic CPOL       = 1'b0,
   parameter int   CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         start,
   input  logic                         continuous,
   input  logic                         miso,
   output logic                         sclk,
   output logic                         cs_n,
   output logic [FRAME_BITS-1:0]        frame_full,
   output logic [DATA_MSB-DATA_LSB:0]   position,
   output logic                         data_valid,
   output logic                         busy,
   output logic [CNT_W-1:0]             frame_count
);

   localparam int MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_B  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TMR_W  = $clog2(MAX_T + 1);
   localparam int EDGE_W = $clog2(2 * FRAME_BITS + 1);

   localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(CS_SETUP - 1);
   localparam logic [TMR_W-1:0]  HALF_LOAD  = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0]  HOLD_LOAD  = TMR_W'(CS_HOLD - 1);
   localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(CS_IDLE - 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * FRAME_BITS);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t                  state_q, state_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [EDGE_W-1:0]       edge_q, edge_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [FRAME_BITS-1:0]   frame_full_q, frame_full_d;
   logic [CNT_W-1:0]        frame_count_q, frame_count_d;
   logic                    sclk_q, sclk_d;
   logic                    cs_n_q, cs_n_d;
   logic                    data_valid_q, data_valid_d;
   logic                    miso_meta_q, miso_meta_d;
   logic                    miso_sync_q, miso_sync_d;

   // Next-state and datapath logic. One down-counter (tmr) times setup, hold,
   // gap and every sclk half-period; edge counts sclk toggles in SHIFT, with
   // the leading edge issued on entry counted as toggle 1.
   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      edge_d        = edge_q;
      shreg_d       = shreg_q;
      frame_full_d  = frame_full_q;
      frame_count_d = frame_count_q;
      sclk_d        = sclk_q;
      cs_n_d        = cs_n_q;
      data_valid_d  = 1'b0;
      miso_meta_d   = miso;
      miso_sync_d   = miso_meta_q;

      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = CPOL;
            if (enable && (start || continuous)) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               tmr_d   = SETUP_LOAD;
            end
         end
         SETUP: begin
            if (tmr_q == '0) begin
               state_d = SHIFT;
               sclk_d  = ~CPOL;
               edge_d  = EDGE_W'(1);
               tmr_d   = HALF_LOAD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         SHIFT: begin
            if (tmr_q == '0) begin
               if (edge_q == LAST_EDGE) begin
                  // last half-period at idle level is complete
                  state_d = HOLD;
                  sclk_d  = CPOL;
                  tmr_d   = HOLD_LOAD;
               end else begin
                  sclk_d = ~sclk_q;
                  edge_d = edge_q + EDGE_W'(1);
                  tmr_d  = HALF_LOAD;
                  // returning to idle level is the trailing (sampling) edge
                  if (sclk_q != CPOL) begin
                     shreg_d = {shreg_q[FRAME_BITS-2:0], miso_sync_q};
                  end
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         HOLD: begin
            if (tmr_q == '0) begin
               state_d       = GAP;
               cs_n_d        = 1'b1;
               frame_full_d  = shreg_q;
               data_valid_d  = 1'b1;
               frame_count_d = frame_count_q + CNT_W'(1);
               tmr_d         = GAP_LOAD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         GAP: begin
            if (tmr_q == '0) begin
               if (enable && continuous) begin
                  state_d = SETUP;
                  cs_n_d  = 1'b0;
                  tmr_d   = SETUP_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = CPOL;
         end
      endcase
   end

   // State register with synchronous reset; all outputs are flop-driven.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         tmr_q         <= '0;
         edge_q        <= '0;
         shreg_q       <= '0;
         frame_full_q  <= '0;
         frame_count_q <= '0;
         sclk_q        <= CPOL;
         cs_n_q        <= 1'b1;
         data_valid_q  <= 1'b0;
         miso_meta_q   <= 1'b0;
         miso_sync_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         edge_q        <= edge_d;
         shreg_q       <= shreg_d;
         frame_full_q  <= frame_full_d;
         frame_count_q <= frame_count_d;
         sclk_q        <= sclk_d;
         cs_n_q        <= cs_n_d;
         data_valid_q  <= data_valid_d;
         miso_meta_q   <= miso_meta_d;
         miso_sync_q   <= miso_sync_d;
      end
   end

   assign sclk        = sclk_q;
   assign cs_n        = cs_n_q;
   assign frame_full  = frame_full_q;
   assign position    = frame_full_q[DATA_MSB:DATA_LSB];
   assign data_valid  = data_valid_q;
   assign busy        = (state_q != IDLE);
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_encoder_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_encoder_reader
// Self-checking bench: an encoder model drives miso from queued or random
// frames, and a scoreboard compares every published frame, the position
// field and the frame counter against plain arithmetic on those frames.
// ---------------------------------------------------------------------------
module tb_spi_encoder_reader;

   localparam int FRAME_BITS = 24;
   localparam int DATA_MSB   = 21;
   localparam int DATA_LSB   = 3;
   localparam int CLK_DIV    = 4;
   localparam int CS_SETUP   = 2;
   localparam int CS_HOLD    = 2;
   localparam int CS_IDLE    = 8;
   localparam int CNT_W      = 4;
   localparam int POS_W      = DATA_MSB - DATA_LSB + 1;
   localparam int CS_LOW_LEN = CS_SETUP + 2 * FRAME_BITS * CLK_DIV + CS_HOLD;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  enable = 1'b0;
   logic                  start = 1'b0;
   logic                  continuous = 1'b0;
   logic                  miso = 1'b0;
   logic                  sclk;
   logic                  cs_n;
   logic [FRAME_BITS-1:0] frame_full;
   logic [POS_W-1:0]      position;
   logic                  data_valid;
   logic                  busy;
   logic [CNT_W-1:0]      frame_count;

   int checks = 0;
   int errors = 0;

   logic [FRAME_BITS-1:0] tx_q[$];
   logic [FRAME_BITS-1:0] exp_q[$];
   logic [FRAME_BITS-1:0] cur_frame = '0;
   int                    bit_idx = 0;
   int                    model_cnt = 0;
   int                    dv_count = 0;

   spi_encoder_reader #(
      .FRAME_BITS(FRAME_BITS), .DATA_MSB(DATA_MSB), .DATA_LSB(DATA_LSB),
      .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
      .CS_IDLE(CS_IDLE), .CPOL(1'b0), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start),
      .continuous(continuous), .miso(miso), .sclk(sclk), .cs_n(cs_n),
      .frame_full(frame_full), .position(position), .data_valid(data_valid),
      .busy(busy), .frame_count(frame_count)
   );

   // 10 time-unit system clock
   always #5 clk = ~clk;

   // Every comparison in the bench goes through here
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Drive the control inputs one cycle at a time, away from the active edge
   task automatic applyStimulus(input logic en, input logic st, input logic co);
      @(negedge clk);
      enable     = en;
      start      = st;
      continuous = co;
   endtask

   // Encoder model: a new frame is latched when chip select falls
   always @(negedge cs_n) begin
      if (tx_q.size() != 0) cur_frame = tx_q.pop_front();
      else                  cur_frame = FRAME_BITS'($urandom);
      exp_q.push_back(cur_frame);
      bit_idx = 0;
   end

   // Encoder model: next bit, MSB first, presented on each rising sclk
   always @(posedge sclk) begin
      if (!cs_n && bit_idx < FRAME_BITS) begin
         miso = cur_frame[FRAME_BITS-1-bit_idx];
         bit_idx++;
      end
   end

   // Scoreboard: each publish must match the oldest frame the encoder sent,
   // outputs must not move between publishes, and chip-select timing is measured
   int         low_len = 0;
   int         high_len = 0;
   bit         seen_frame = 1'b0;
   logic       prev_dv = 1'b0;
   logic [FRAME_BITS-1:0] prev_frame = '0;
   always @(negedge clk) begin
      logic [FRAME_BITS-1:0] f;
      if (rst) begin
         low_len    = 0;
         high_len   = 0;
         seen_frame = 1'b0;
      end else begin
         if (data_valid) begin
            dv_count++;
            checkOutput("dv_width", 32'(prev_dv), 0);
            if (exp_q.size() == 0) begin
               checkOutput("dv_unexpected", 1, 0);
            end else begin
               f = exp_q.pop_front();
               model_cnt = (model_cnt + 1) % (1 << CNT_W);
               checkOutput("frame_full", 32'(frame_full), 32'(f));
               checkOutput("position", 32'(position), (32'(f) >> DATA_LSB) & ((32'd1 << POS_W) - 1));
               checkOutput("frame_count", 32'(frame_count), 32'(model_cnt));
            end
         end else begin
            checkOutput("hold_stable", 32'(frame_full), 32'(prev_frame));
         end
         if (!cs_n) begin
            if (low_len == 0 && seen_frame) checkOutput("cs_gap_min", 32'(high_len >= CS_IDLE), 1);
            low_len++;
            high_len = 0;
         end else begin
            if (low_len != 0) begin
               checkOutput("cs_low_len", 32'(low_len), 32'(CS_LOW_LEN));
               seen_frame = 1'b1;
            end
            low_len = 0;
            high_len++;
         end
      end
      prev_dv    = data_valid;
      prev_frame = frame_full;
   end

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; enable = 1'b0; start = 1'b0; continuous = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      tx_q.delete();
      model_cnt = 0;
      rst = 1'b0;
   endtask

   task automatic waitValid(input string tag, input int maxCycles);
      bit seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         if (data_valid) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 1);
   endtask

   task automatic waitCsLow(input string tag, input int maxCycles);
      bit seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         if (!cs_n) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 1);
   endtask

   task automatic waitIdle(input string tag, input int maxCycles);
      bit seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 1);
   endtask

   task automatic waitSclkFalls(input string tag, input int n, input int maxCycles);
      int   falls = 0;
      logic prev = sclk;
      for (int i = 0; i < maxCycles && falls < n; i++) begin
         @(negedge clk);
         if (prev && !sclk) falls++;
         prev = sclk;
      end
      checkOutput(tag, 32'(falls), 32'(n));
   endtask

   // Main test sequence
   initial begin
      logic [FRAME_BITS-1:0] v;
      int dv_before;
      int low_seen;

      // 1. reset holds everything quiet even with inputs toggling
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_cs_n", 32'(cs_n), 1);
         checkOutput("rst_sclk", 32'(sclk), 0);
         checkOutput("rst_busy", 32'(busy), 0);
         checkOutput("rst_dv", 32'(data_valid), 0);
         checkOutput("rst_frame", 32'(frame_full), 0);
         checkOutput("rst_count", 32'(frame_count), 0);
         enable = 1'($urandom); start = 1'($urandom); continuous = 1'($urandom);
      end
      doReset();

      // 2. one-shot frame
      tx_q.push_back(24'hA5C3F1);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 0, 0);
      waitValid("t2_valid", 400);
      checkOutput("t2_frame", 32'(frame_full), 32'hA5C3F1);
      checkOutput("t2_pos", 32'(position), 32'h4B87E);
      checkOutput("t2_count", 32'(frame_count), 1);
      waitIdle("t2_idle", CS_IDLE + 4);
      checkOutput("t2_cs_idle", 32'(cs_n), 1);

      // 3. continuous mode, three frames
      doReset();
      tx_q.push_back(24'h000001);
      tx_q.push_back(24'hFFFFFF);
      tx_q.push_back(24'h800000);
      applyStimulus(1, 0, 1);
      waitValid("t3_valid1", 400);
      checkOutput("t3_pos1", 32'(position), 32'h00000);
      checkOutput("t3_cnt1", 32'(frame_count), 1);
      waitValid("t3_valid2", 400);
      checkOutput("t3_pos2", 32'(position), 32'h7FFFF);
      checkOutput("t3_cnt2", 32'(frame_count), 2);
      waitCsLow("t3_cs3", 40);
      applyStimulus(1, 0, 0);
      waitValid("t3_valid3", 400);
      checkOutput("t3_pos3", 32'(position), 32'h00000);
      checkOutput("t3_cnt3", 32'(frame_count), 3);
      waitIdle("t3_idle", CS_IDLE + 4);

      // 4. enable drops mid-frame, start pulsed while busy
      doReset();
      tx_q.push_back(FRAME_BITS'($urandom));
      applyStimulus(1, 0, 1);
      waitCsLow("t4_cs", 20);
      waitSclkFalls("t4_bits", 10, 200);
      applyStimulus(0, 1, 1);
      applyStimulus(0, 0, 1);
      checkOutput("t4_busy", 32'(busy), 1);
      dv_before = dv_count;
      waitValid("t4_valid", 400);
      waitIdle("t4_idle", CS_IDLE + 4);
      low_seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (!cs_n) low_seen++;
      end
      checkOutput("t4_one_frame", 32'(dv_count - dv_before), 1);
      checkOutput("t4_cs_quiet", 32'(low_seen), 0);
      applyStimulus(0, 0, 0);

      // 5. reset mid-frame, then a clean frame
      doReset();
      tx_q.push_back(FRAME_BITS'($urandom));
      applyStimulus(1, 1, 0);
      applyStimulus(1, 0, 0);
      waitCsLow("t5_cs", 20);
      waitSclkFalls("t5_bits", 12, 200);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5_cs_n", 32'(cs_n), 1);
      checkOutput("t5_sclk", 32'(sclk), 0);
      checkOutput("t5_dv", 32'(data_valid), 0);
      checkOutput("t5_frame", 32'(frame_full), 0);
      checkOutput("t5_count", 32'(frame_count), 0);
      checkOutput("t5_busy", 32'(busy), 0);
      doReset();
      v = FRAME_BITS'($urandom);
      tx_q.push_back(v);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 0, 0);
      waitValid("t5_valid", 400);
      checkOutput("t5_frame2", 32'(frame_full), 32'(v));
      checkOutput("t5_count2", 32'(frame_count), 1);
      waitIdle("t5_idle", CS_IDLE + 4);

      // 6. counter wrap over 17 random frames
      doReset();
      applyStimulus(1, 0, 1);
      for (int i = 1; i <= 17; i++) begin
         waitValid("t6_valid", 400);
         checkOutput("t6_count", 32'(frame_count), 32'(i % (1 << CNT_W)));
      end
      applyStimulus(1, 0, 0);
      waitIdle("t6_idle", CS_IDLE + 4);
      checkOutput("t6_pending", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_encoder_reader.md
Name: spi_encoder_reader

Overview:
- Parametrised read-only SPI master for absolute rotary encoders (24-bit frame, 19-bit position field by default).
- Generates sclk and cs_n from the system clock. Shifts in one frame MSB-first, then extracts the position field.
- Runs in one-shot or continuous-polling mode. Publishes each frame with a single-cycle valid pulse and a frame counter.
- Sits between the encoder connector pins and the MicroBlaze-side register interface.

Parameters:
- FRAME_BITS, 24: bits per SPI frame.
- DATA_MSB, 21: MSB index of the position field within the frame.
- DATA_LSB, 3: LSB index of the position field within the frame.
- CLK_DIV, 100: clk cycles per sclk half-period; must be >= 4. Gives sclk = clk/(2*CLK_DIV).
- CS_SETUP, 100: clk cycles from cs_n falling to first sclk edge.
- CS_HOLD, 100: clk cycles from last sclk edge to cs_n rising.
- CS_IDLE, 200: minimum clk cycles cs_n stays high between frames.
- CPOL, 0: sclk idle level.
- CNT_W, 16: width of frame_count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  block enable; start and continuous are ignored when low
- start  in  1  one-shot request pulse, sampled in IDLE only
- continuous  in  1  when high with enable high, frames repeat back-to-back
- miso  in  1  encoder serial data (asynchronous)
- sclk  out  1  SPI clock
- cs_n  out  1  chip select, active-low
- frame_full  out  FRAME_BITS  last complete raw frame
- position  out  DATA_MSB-DATA_LSB+1  frame_full[DATA_MSB:DATA_LSB]
- data_valid  out  1  one-clk pulse when frame_full/position update
- busy  out  1  high whenever state != IDLE
- frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset values: cs_n=1, sclk=CPOL, frame_full=0, position=0, data_valid=0, busy=0, frame_count=0, state=IDLE. The miso synchroniser flops are also cleared.
- miso passes through a 2-flop synchroniser before use.
- States: IDLE, SETUP, SHIFT, HOLD, GAP. A single down-counter times SETUP, HOLD, GAP and the half-periods; a bit counter tracks SHIFT.
- IDLE:
  - cs_n=1.
  - Go to SETUP when enable && (start || continuous).
  - cs_n falls on the first SETUP cycle (registered).
- SETUP:
  - cs_n=0, sclk=CPOL for CS_SETUP cycles, then SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles. The first toggle, the leading edge (away from CPOL), occurs on entry.
  - On each trailing edge (return to CPOL), shift in the synchronised miso: shreg <= {shreg[FRAME_BITS-2:0], miso_s}. MSB arrives first.
  - The encoder updates data on leading edges. Sampling at the trailing edge leaves CLK_DIV-2 cycles of margin after synchroniser delay.
  - After exactly FRAME_BITS trailing edges (2*FRAME_BITS toggles), go to HOLD with sclk=CPOL.
- HOLD:
  - cs_n=0 for CS_HOLD cycles.
  - On exit: cs_n<=1, frame_full<=shreg, position<=shreg[DATA_MSB:DATA_LSB], data_valid pulses for exactly 1 cycle, frame_count increments (wraps).
  - Then GAP.
- GAP:
  - cs_n=1 for CS_IDLE cycles.
  - Then SETUP if enable && continuous, else IDLE.
- Frame timing: cs_n low for exactly CS_SETUP + 2*FRAME_BITS*CLK_DIV + CS_HOLD cycles.
- Output stability: frame_full and position hold their value until the next data_valid. No partial frame is ever visible on them.
- Boundary conditions:
  - start while busy: ignored. Not queued.
  - start and continuous both high: same as continuous.
  - enable falls mid-frame: current frame completes and is published; GAP then goes to IDLE.
  - continuous falls mid-frame: same as enable falling mid-frame.
  - rst mid-frame: next cycle cs_n=1, sclk=CPOL, IDLE. No data_valid is produced; all outputs return to reset values.
  - frame_count at 2^CNT_W-1: the next frame sets it to 0.
- Combinational paths: none from inputs to outputs. sclk and cs_n are registered outputs.

Test Plan:
Bench parameters: FRAME_BITS=24, DATA_MSB=21, DATA_LSB=3, CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, CS_IDLE=8, CPOL=0, CNT_W=4. The encoder model drives miso on rising sclk.
1. Reset check: assert rst for 3 cycles, inputs toggling -> cs_n=1, sclk=0, busy=0, data_valid=0, frame_full=0, frame_count=0 throughout.
2. One-shot frame: enable=1, start pulse, model frame 0xA5C3F1 -> 24 sclk periods; cs_n low exactly 196 cycles; frame_full=0xA5C3F1, position=0x4B87E; data_valid high 1 cycle; frame_count=1; returns to IDLE.
3. Continuous mode: enable=1, continuous=1, frames 0x000001, 0xFFFFFF, 0x800000 -> three data_valid pulses. position=0x00000, 0x7FFFF, 0x00000; frame_count=1,2,3; cs_n high >= 8 cycles between frames.
4. Mid-frame stop and busy start: continuous=1, drop enable after bit 10, pulse start during SHIFT -> current frame completes and is published; no further frame; start has no effect; busy falls after GAP.
5. Reset mid-frame: assert rst at bit 12 of a frame -> next cycle cs_n=1, sclk=0, no data_valid, frame_full/frame_count=0. A subsequent start yields a correct full frame.
6. Counter wrap: continuous run of 17 frames -> frame_count sequence 1..15,0,1; every frame_full matches the model.
